// File: rtl/controle_jogo_pkg.sv
// Shared definitions for the round-based sequence-memory game controller.
package controle_jogo_pkg;

  // FSM state encodings; the numeric value is exported on db_estado.
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    INICIO_RODADA  = 4'd2,
    ESPERA_JOGADA  = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_ACERTOS    = 4'd8,
    FIM_ERRO       = 4'd9,
    FIM_TIMEOUT    = 4'd10
  } estado_t;

endpackage

// File: rtl/temporizador_inatividade.sv
// Inactivity timer: counts enabled cycles and flags when the count reaches M-1.
module temporizador_inatividade #(
  parameter int unsigned M = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;

  logic [W-1:0] r_cont;

  // Count register; clear has priority, and the count saturates at M-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cont <= '0;
    end else if (zera) begin
      r_cont <= '0;
    end else if (conta && !fim) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  assign fim = (r_cont == W'(M - 1));

endmodule

// File: rtl/controle_jogo_rodadas.sv
// Round-based control unit for the sequence-memory game: owns the position
// counter, the round counter and the inactivity timer.
module controle_jogo_rodadas
  import controle_jogo_pkg::*;
#(
  parameter int unsigned N_RODADAS      = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CICLOS = 3000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  input  logic              modo_timeout,
  output logic              zeraR,
  output logic              registraR,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  estado_t           r_estado;
  estado_t           w_proximo;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_rodada;
  logic              r_modo;
  logic              w_zera_timer;
  logic              w_conta_timer;
  logic              w_fim_timer;
  logic              w_fim_rodada;
  logic              w_ultima_rodada;

  assign w_fim_rodada    = (r_endereco == r_rodada);
  assign w_ultima_rodada = (r_rodada == ADDR_W'(N_RODADAS - 1));

  // The timer only advances while waiting for a play with timeout enabled,
  // so with the mode off it stays at zero and can never expire.
  assign w_zera_timer  = (r_estado == PREPARA) || (r_estado == INICIO_RODADA) ||
                         (r_estado == REGISTRA);
  assign w_conta_timer = (r_estado == ESPERA_JOGADA) && r_modo;

  temporizador_inatividade #(
    .M (TIMEOUT_CICLOS)
  ) u_temporizador (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera_timer),
    .conta (w_conta_timer),
    .fim   (w_fim_timer)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Position/round counters and timeout-mode latch, driven by the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= '0;
      r_rodada   <= '0;
      r_modo     <= 1'b0;
    end else begin
      case (r_estado)
        PREPARA: begin
          r_endereco <= '0;
          r_rodada   <= '0;
          r_modo     <= modo_timeout;
        end
        INICIO_RODADA:  r_endereco <= '0;
        PROXIMA_JOGADA: r_endereco <= r_endereco + 1'b1;
        PROXIMA_RODADA: r_rodada   <= r_rodada + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; a play wins over timer expiry on the same cycle.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL:        if (iniciar) w_proximo = PREPARA;
      PREPARA:        w_proximo = INICIO_RODADA;
      INICIO_RODADA:  w_proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)           w_proximo = REGISTRA;
        else if (w_fim_timer) w_proximo = FIM_TIMEOUT;
      end
      REGISTRA:       w_proximo = COMPARA;
      COMPARA: begin
        if (!igual)                             w_proximo = FIM_ERRO;
        else if (w_fim_rodada && w_ultima_rodada) w_proximo = FIM_ACERTOS;
        else if (w_fim_rodada)                  w_proximo = PROXIMA_RODADA;
        else                                    w_proximo = PROXIMA_JOGADA;
      end
      PROXIMA_JOGADA: w_proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: w_proximo = INICIO_RODADA;
      FIM_ACERTOS,
      FIM_ERRO,
      FIM_TIMEOUT:    if (iniciar) w_proximo = PREPARA;
      default:        w_proximo = INICIAL;
    endcase
  end

  // Moore output decode from the registered state only.
  always_comb begin
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (r_estado)
      INICIAL,
      PREPARA:     zeraR = 1'b1;
      REGISTRA:    registraR = 1'b1;
      FIM_ACERTOS: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      FIM_ERRO: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      FIM_TIMEOUT: begin
        errou   = 1'b1;
        timeout = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  assign endereco  = r_endereco;
  assign rodada    = r_rodada;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_controle_jogo_rodadas.sv
// Self-checking bench for controle_jogo_rodadas (N_RODADAS=4, TIMEOUT_CICLOS=10).
module tb_controle_jogo_rodadas;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar = 1'b0;
  logic          jogada = 1'b0;
  logic          igual = 1'b0;
  logic          modo_timeout = 1'b0;
  logic          zeraR, registraR, acertou, errou, timeout, pronto;
  logic [AW-1:0] endereco, rodada;
  logic [3:0]    db_estado;

  int n_chk  = 0;
  int n_fail = 0;
  int n_step = 0;

  typedef struct {
    logic [3:0] st;
    logic [3:0] en;
    logic [3:0] ro;
    int         idx;
  } exp_t;

  typedef struct {
    logic       ini;
    logic       jog;
    logic       ig;
    logic [3:0] st;
    logic [3:0] en;
    logic [3:0] ro;
  } vec_t;

  exp_t sb[$];
  exp_t m_e;
  vec_t tab[11];

  controle_jogo_rodadas #(
    .N_RODADAS      (NR),
    .ADDR_W         (AW),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .jogada       (jogada),
    .igual        (igual),
    .modo_timeout (modo_timeout),
    .zeraR        (zeraR),
    .registraR    (registraR),
    .endereco     (endereco),
    .rodada       (rodada),
    .acertou      (acertou),
    .errou        (errou),
    .timeout      (timeout),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  // Expected {zeraR, registraR, acertou, errou, timeout, pronto} per state.
  function automatic logic [5:0] flags_de(input logic [3:0] st);
    case (st)
      4'd0, 4'd1: return 6'b100000;
      4'd4:       return 6'b010000;
      4'd8:       return 6'b001001;
      4'd9:       return 6'b000101;
      4'd10:      return 6'b000111;
      default:    return 6'b000000;
    endcase
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic ini, input logic jog, input logic ig,
                      input int st, input int en, input int ro);
    exp_t e;
    @(negedge clock);
    iniciar = ini;
    jogada  = jog;
    igual   = ig;
    e.st  = 4'(st);
    e.en  = 4'(en);
    e.ro  = 4'(ro);
    e.idx = n_step;
    n_step++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input int st, input int en, input int ro);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, igual, st, en, ro);
  endtask

  // From inicial or a final state holding (en_prev, ro_prev) to espera_jogada.
  task automatic start(input int en_prev, input int ro_prev);
    step(1'b1, 1'b0, igual, 1, en_prev, ro_prev);
    step(1'b0, 1'b0, igual, 2, 0, 0);
    step(1'b0, 1'b0, igual, 3, 0, 0);
  endtask

  // One play at position p of round r, starting in espera_jogada.
  task automatic play(input int p, input int r, input logic ig);
    step(1'b0, 1'b1, ig, 4, p, r);
    step(1'b0, 1'b0, ig, 5, p, r);
    if (!ig) begin
      step(1'b0, 1'b0, ig, 9, p, r);
    end else if (p == r && r == int'(NR) - 1) begin
      step(1'b0, 1'b0, ig, 8, p, r);
    end else if (p == r) begin
      step(1'b0, 1'b0, ig, 7, p, r);
      step(1'b0, 1'b0, ig, 2, p, r + 1);
      step(1'b0, 1'b0, ig, 3, 0, r + 1);
    end else begin
      step(1'b0, 1'b0, ig, 6, p, r);
      step(1'b0, 1'b0, ig, 3, p + 1, r);
    end
  endtask

  // Scoreboard consumer: compare one queued expectation per clock edge.
  always @(posedge clock) begin
    #1;
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk("estado",   m_e.idx, 8'(db_estado), 8'(m_e.st));
      chk("endereco", m_e.idx, 8'(endereco),  8'(m_e.en));
      chk("rodada",   m_e.idx, 8'(rodada),    8'(m_e.ro));
      chk("flags",    m_e.idx,
          8'({zeraR, registraR, acertou, errou, timeout, pronto}), 8'(flags_de(m_e.st)));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, checked asynchronously before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_estado",   -1, 8'(db_estado), 8'd0);
    chk("rst_endereco", -1, 8'(endereco),  8'd0);
    chk("rst_rodada",   -1, 8'(rodada),    8'd0);
    chk("rst_flags",    -1, 8'({zeraR, registraR, acertou, errou, timeout, pronto}), 8'b0010_0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Start and round 0, including plays ignored outside espera_jogada.
    tab[0]  = '{1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0};
    tab[1]  = '{1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0};
    tab[2]  = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0};
    tab[3]  = '{1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0};
    tab[4]  = '{1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0};
    tab[5]  = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0};
    tab[6]  = '{1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0};
    tab[7]  = '{1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0};
    tab[8]  = '{1'b0, 1'b0, 1'b1, 4'd7, 4'd0, 4'd0};
    tab[9]  = '{1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd1};
    tab[10] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd1};
    for (int i = 0; i < 11; i++) begin
      step(tab[i].ini, tab[i].jog, tab[i].ig, int'(tab[i].st), int'(tab[i].en), int'(tab[i].ro));
    end

    // Full correct game: rounds 1..3 (10 plays in total), then hold.
    for (int r = 1; r < int'(NR); r++) begin
      for (int p = 0; p <= r; p++) play(p, r, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 8, 3, 3);

    // Error in round 2 at position 1.
    start(3, 3);
    play(0, 0, 1'b1);
    play(0, 1, 1'b1);
    play(1, 1, 1'b1);
    play(0, 2, 1'b1);
    play(1, 2, 1'b0);
    idle(1, 9, 1, 2);

    // Timeout: 10 cycles in espera_jogada, then fim_timeout.
    modo_timeout = 1'b1;
    start(1, 2);
    idle(TO - 1, 3, 0, 0);
    idle(2, 10, 0, 0);

    // Play on the expiry cycle inside a round, then a full fresh timeout.
    start(0, 0);
    play(0, 0, 1'b1);
    idle(TO - 1, 3, 0, 1);
    step(1'b0, 1'b1, 1'b1, 4, 0, 1);
    step(1'b0, 1'b0, 1'b1, 5, 0, 1);
    step(1'b0, 1'b0, 1'b1, 6, 0, 1);
    step(1'b0, 1'b0, 1'b1, 3, 1, 1);
    idle(TO - 1, 3, 1, 1);
    idle(1, 10, 1, 1);

    // Timeout disabled, then enabled mid-game without a new prepara.
    modo_timeout = 1'b0;
    start(1, 1);
    idle(3 * TO, 3, 0, 0);
    modo_timeout = 1'b1;
    idle(3 * TO, 3, 0, 0);

    // Asynchronous reset during round 1.
    play(0, 0, 1'b1);
    play(0, 1, 1'b1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("arst_estado",   -2, 8'(db_estado), 8'd0);
    chk("arst_endereco", -2, 8'(endereco),  8'd0);
    chk("arst_rodada",   -2, 8'(rodada),    8'd0);
    @(negedge clock);
    reset = 1'b0;
    modo_timeout = 1'b0;
    start(0, 0);
    play(0, 0, 1'b1);
    play(0, 1, 1'b0);
    start(0, 1);
    idle(2, 3, 0, 0);

    @(posedge clock);
    #2;
    chk("drain", -3, 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
